// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier sequencer around the datapath alu; start/busy/done.
// Ports: clk, reset (async, active-low), Start, Multiplicand, Multiplier,
//   Busy, Done, Product {Hi,Lo}. Define ALU_MUL_SIGNED_EN to add the Signed port.
module alu #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   ALUControl,
  output logic [N-1:0] Result,
  output logic [3:0]   ALUFlags
);
  logic [N-1:0] b_eff;
  logic [N:0]   sum;
  logic         arith;

  always_comb begin
    arith = (ALUControl[2:1] == 2'b00);
    b_eff = ALUControl[0] ? ~B : B;
    sum = {1'b0, A} + {1'b0, b_eff} + {{N{1'b0}}, ALUControl[0]};
    unique case (ALUControl)
      3'b010:  Result = A & B;
      3'b011:  Result = A | B;
      default: Result = sum[N-1:0];
    endcase
    ALUFlags[3] = Result[N-1];
    ALUFlags[2] = (Result == '0);
    ALUFlags[1] = arith & sum[N];
    ALUFlags[0] = arith & ~(A[N-1] ^ b_eff[N-1]) & (A[N-1] ^ sum[N-1]);
  end
endmodule

module alu_mul_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           Start,
`ifdef ALU_MUL_SIGNED_EN
  input  logic           Signed,
`endif
  input  logic [N-1:0]   Multiplicand,
  input  logic [N-1:0]   Multiplier,
  output logic           Busy,
  output logic           Done,
  output logic [2*N-1:0] Product
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  m_q, m_d;
  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef ALU_MUL_SIGNED_EN
  logic          sgn_q, sgn_d;
`endif

  logic [2:0]   alu_ctl;
  logic [N-1:0] alu_res;
  logic [3:0]   alu_flags;
  logic         unused_flags;
  logic         last;
  logic         use_alu;
  logic [N-1:0] sum;
  logic         cin;

  assign last = (cnt_q == LAST);

  // Signed: the top multiplier bit has negative weight, so subtract it.
`ifdef ALU_MUL_SIGNED_EN
  assign alu_ctl = (sgn_q && last) ? 3'b001 : 3'b000;
`else
  assign alu_ctl = 3'b000;
`endif

  alu #(.N(N)) u_alu (
    .A          (hi_q),
    .B          (m_q),
    .ALUControl (alu_ctl),
    .Result     (alu_res),
    .ALUFlags   (alu_flags)
  );

  assign unused_flags = ^alu_flags;

  always_comb begin
    use_alu = lo_q[0];
    sum = use_alu ? alu_res : hi_q;
`ifdef ALU_MUL_SIGNED_EN
    // Signed: true sign of the partial sum is N xor V.
    if (sgn_q)
      cin = use_alu ? (sum[N-1] ^ alu_flags[0]) : hi_q[N-1];
    else
      cin = use_alu & alu_flags[1];
`else
    cin = use_alu & alu_flags[1];
`endif
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
`ifdef ALU_MUL_SIGNED_EN
    sgn_d   = sgn_q;
`endif
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (Start) begin
          m_d     = Multiplicand;
          hi_d    = '0;
          lo_d    = Multiplier;
          cnt_d   = '0;
`ifdef ALU_MUL_SIGNED_EN
          sgn_d   = Signed;
`endif
          state_d = S_RUN;
        end
      end
      (state_q == S_RUN): begin
        hi_d  = {cin, sum[N-1:1]};
        lo_d  = {sum[0], lo_q[N-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
`ifdef ALU_MUL_SIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
`ifdef ALU_MUL_SIGNED_EN
      sgn_q   <= sgn_d;
`endif
    end
  end

  assign Busy    = (state_q == S_RUN);
  assign Done    = (state_q == S_DONE);
  assign Product = {hi_q, lo_q};
endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: scoreboard of expected products,
// popped and compared on every Done pulse.
module tb_alu_mul_seq;
  localparam int N = 4;

  logic           clk;
  logic           reset;
  logic           Start;
  logic           Signed;
  logic [N-1:0]   Multiplicand;
  logic [N-1:0]   Multiplier;
  logic           Busy;
  logic           Done;
  logic [2*N-1:0] Product;

  int tests;
  int fails;
  int done_cnt;
  int issued;
  logic [2*N-1:0] sb[$];

  alu_mul_seq #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .Start        (Start),
`ifdef ALU_MUL_SIGNED_EN
    .Signed       (Signed),
`endif
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Busy         (Busy),
    .Done         (Done),
    .Product      (Product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*N-1:0] model(input logic [N-1:0] a,
                                           input logic [N-1:0] b,
                                           input logic s);
    logic [2*N-1:0] ea;
    logic [2*N-1:0] eb;
    ea = s ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
    eb = s ? {{N{b[N-1]}}, b} : {{N{1'b0}}, b};
    return ea * eb;
  endfunction

  always @(negedge clk) begin
    if (Done) begin
      done_cnt++;
      if (sb.size() == 0) chk("unexpected_done", 32'(Done), 32'd0);
      else chk("product", 32'(Product), 32'(sb.pop_front()));
    end
  end

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic s, input logic hold);
    int cyc;
    int busy;
    @(negedge clk);
    Start = 1'b1;
    Multiplicand = a;
    Multiplier = b;
    Signed = s;
`ifdef ALU_MUL_SIGNED_EN
    sb.push_back(model(a, b, s));
`else
    sb.push_back(model(a, b, 1'b0));
`endif
    issued++;
    @(posedge clk);
    #1;
    if (hold) begin
      Multiplicand = 4'h1;
      Multiplier = 4'h1;
    end else begin
      Start = 1'b0;
    end
    cyc = 0;
    busy = 0;
    while (cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (Busy) busy++;
      if (Done) break;
    end
    chk("done_latency", 32'(cyc), 32'(N + 1));
    chk("busy_cycles", 32'(busy), 32'(N));
    @(negedge clk);
    chk("done_pulse_low", 32'(Done), 32'd0);
    chk("idle_not_busy", 32'(Busy), 32'd0);
    Start = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    done_cnt = 0;
    issued = 0;
    reset = 1'b0;
    Start = 1'b0;
    Signed = 1'b0;
    Multiplicand = '0;
    Multiplier = '0;
    @(negedge clk);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_product", 32'(Product), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(4'hF, 4'hF, 1'b0, 1'b0);
    run_op(4'h3, 4'h5, 1'b0, 1'b0);
    run_op(4'h0, 4'h9, 1'b0, 1'b0);
    run_op(4'h2, 4'h7, 1'b0, 1'b1);
    @(negedge clk);
    chk("hold_product", 32'(Product), 32'h0E);
    chk("hold_no_restart", 32'(Busy), 32'd0);

    @(negedge clk);
    Start = 1'b1;
    Multiplicand = 4'hF;
    Multiplier = 4'hF;
    @(posedge clk);
    #1;
    Start = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_run_busy", 32'(Busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_done", 32'(Done), 32'd0);
    chk("mid_rst_product", 32'(Product), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_op(4'h6, 4'h6, 1'b0, 1'b0);

`ifdef ALU_MUL_SIGNED_EN
    run_op(4'hD, 4'h5, 1'b1, 1'b0);
    chk("s_m3x5", 32'(Product), 32'hF1);
    run_op(4'h8, 4'h8, 1'b1, 1'b0);
    chk("s_m8xm8", 32'(Product), 32'h40);
    run_op(4'h7, 4'hF, 1'b1, 1'b0);
    chk("s_7xm1", 32'(Product), 32'hF9);
    run_op(4'hD, 4'h5, 1'b0, 1'b0);
    chk("u_13x5", 32'(Product), 32'h41);
`endif

    for (int i = 0; i < 12; i++) begin
      run_op(N'($urandom), N'($urandom), 1'($urandom), 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("done_count", 32'(done_cnt), 32'(issued));
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
